// File: rtl/sram_1rw_req_ctrl.sv
// Valid/ready request front-end for a 1RW synchronous SRAM macro, with an in-order read response FIFO.
// Optional power-up zero fill of the whole array when SRAM_CTRL_INIT_ZERO_EN is defined.
module sram_1rw_req_ctrl #(
  parameter int width_p      = 46,
  parameter int els_p        = 1024,
  parameter int addr_width_p = $clog2(els_p),
  parameter int fifo_els_p   = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic                    w_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [width_p-1:0]      data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  input  logic                    ready_i,
  output logic                    init_done_o,
  output logic                    sram_cen_o,
  output logic                    sram_gwen_o,
  output logic [width_p-1:0]      sram_wen_o,
  output logic [addr_width_p-1:0] sram_a_o,
  output logic [width_p-1:0]      sram_d_o,
  input  logic [width_p-1:0]      sram_q_i
);

  localparam int cnt_w = $clog2(fifo_els_p + 1);
  localparam int ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;

  localparam logic [0:0] STATE_INIT = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;
`ifdef SRAM_CTRL_INIT_ZERO_EN
  localparam logic [0:0] STATE_RESET = STATE_INIT;
`else
  localparam logic [0:0] STATE_RESET = STATE_RUN;
`endif

  logic [0:0]       state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic [ptr_w-1:0] wptr_q, wptr_d;
  logic [ptr_w-1:0] rptr_q, rptr_d;
  logic [cnt_w-1:0] fill_q, fill_d;
  logic [width_p-1:0] fifo_mem_q [fifo_els_p];
`ifdef SRAM_CTRL_INIT_ZERO_EN
  logic [addr_width_p-1:0] init_addr_q, init_addr_d;
`endif

  logic accept;
  logic rd_accept;
  logic push;
  logic pop;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    ptr_inc = (p == ptr_w'(fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset is asynchronous, so gate the handshake outputs directly with it.
  assign init_done_o = (state_q == STATE_RUN) & ~reset_i;
  assign ready_o     = init_done_o & (cnt_q < cnt_w'(fifo_els_p));
  assign accept      = v_i & ready_o;
  assign rd_accept   = accept & ~w_i;
  assign v_o         = (fill_q != '0);
  assign pop         = v_o & ready_i;
  assign push        = rd_pend_q;
  assign data_o      = v_o ? fifo_mem_q[rptr_q] : '0;
  assign sram_wen_o  = '0;

  always_comb begin
    sram_cen_o  = ~accept;
    sram_gwen_o = ~w_i;
    sram_a_o    = addr_i;
    sram_d_o    = data_i;
`ifdef SRAM_CTRL_INIT_ZERO_EN
    if (state_q == STATE_INIT && !reset_i) begin
      sram_cen_o  = 1'b0;
      sram_gwen_o = 1'b0;
      sram_a_o    = init_addr_q;
      sram_d_o    = '0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
`ifdef SRAM_CTRL_INIT_ZERO_EN
    init_addr_d = init_addr_q;
`endif
    if (state_q == STATE_INIT) begin
`ifdef SRAM_CTRL_INIT_ZERO_EN
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == addr_width_p'(els_p - 1)) begin
        state_d = STATE_RUN;
      end
`else
      state_d = STATE_RUN;
`endif
    end
  end

  // cnt covers reads in flight plus buffered responses, so it gates FIFO overflow.
  always_comb begin
    cnt_d = cnt_q;
    case ({rd_accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    rd_pend_d = rd_accept;
    wptr_d    = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d    = pop  ? ptr_inc(rptr_q) : rptr_q;
    fill_d    = fill_q + cnt_w'(push) - cnt_w'(pop);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= STATE_RESET;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fill_q    <= fill_d;
    end
  end

`ifdef SRAM_CTRL_INIT_ZERO_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      init_addr_q <= '0;
    end else begin
      init_addr_q <= init_addr_d;
    end
  end
`endif

  // Storage needs no reset: data_o is masked until an entry is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wptr_q] <= sram_q_i;
    end
  end

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Bench for sram_1rw_req_ctrl: SRAM macro model, queue-based response model, directed and random traffic.
// Also covers the SRAM_CTRL_INIT_ZERO_EN build when that macro is defined.
module tb_sram_1rw_req_ctrl;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_i, w_i, ready_i;
  logic [9:0]  addr_i;
  logic [45:0] data_i;
  logic        ready_o, v_o, init_done_o;
  logic [45:0] data_o;
  logic        sram_cen_o, sram_gwen_o;
  logic [45:0] sram_wen_o, sram_d_o, sram_q_i;
  logic [9:0]  sram_a_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int run_cyc = 0;

  typedef struct {
    logic [45:0] d;
    int          t;
  } resp_t;
  resp_t rq[$];

  logic [45:0] sram_mem [1024];
  logic [45:0] ref_mem  [1024];

  always #5 clk = ~clk;

  sram_1rw_req_ctrl dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .w_i         (w_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .v_o         (v_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .init_done_o (init_done_o),
    .sram_cen_o  (sram_cen_o),
    .sram_gwen_o (sram_gwen_o),
    .sram_wen_o  (sram_wen_o),
    .sram_a_o    (sram_a_o),
    .sram_d_o    (sram_d_o),
    .sram_q_i    (sram_q_i)
  );

  // Macro model: write completes on the edge, read data appears after the edge.
  always @(posedge clk) begin
    if (!sram_cen_o) begin
      if (!sram_gwen_o) begin
        sram_mem[sram_a_o] <= (sram_mem[sram_a_o] & sram_wen_o) | (sram_d_o & ~sram_wen_o);
      end else begin
        sram_q_i <= sram_mem[sram_a_o];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: credits = size of the response queue; a read becomes visible two cycles after accept.
  always @(negedge clk) begin : model
    logic exp_done, exp_ready, exp_v, acc;
    if (cyc > 0) begin
      if (reset_i) begin
        chk("rst_ready_o", ready_o, 0);
        chk("rst_v_o", v_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_init_done_o", init_done_o, 0);
        chk("rst_cen", sram_cen_o, 1);
        rq.delete();
        run_cyc = 0;
      end else begin
`ifdef SRAM_CTRL_INIT_ZERO_EN
        exp_done = (run_cyc >= 1024);
`else
        exp_done = 1'b1;
`endif
        exp_ready = exp_done && (rq.size() < 3);
        exp_v = 1'b0;
        if (rq.size() > 0) exp_v = (rq[0].t <= cyc);
        chk("init_done_o", init_done_o, exp_done);
        chk("ready_o", ready_o, exp_ready);
        chk("v_o", v_o, exp_v);
        chk("wen", sram_wen_o, 0);
        if (exp_v) chk("data_o", data_o, rq[0].d);
        acc = v_i && exp_ready;
        if (!exp_done) begin
          chk("init_cen", sram_cen_o, 0);
          chk("init_gwen", sram_gwen_o, 0);
          chk("init_a", sram_a_o, 64'(run_cyc));
          chk("init_d", sram_d_o, 0);
          ref_mem[run_cyc] = '0;
        end else if (acc) begin
          chk("acc_cen", sram_cen_o, 0);
          chk("acc_gwen", sram_gwen_o, !w_i);
          chk("acc_a", sram_a_o, addr_i);
          if (w_i) begin
            chk("acc_d", sram_d_o, data_i);
          end
        end else begin
          chk("idle_cen", sram_cen_o, 1);
        end
        if (exp_v && ready_i) void'(rq.pop_front());
        if (exp_done && acc) begin
          if (w_i) ref_mem[addr_i] = data_i;
          else rq.push_back('{d: ref_mem[addr_i], t: cyc + 2});
        end
        run_cyc++;
      end
    end
    cyc++;
  end

  task automatic step(input logic v, input logic w, input logic [9:0] a, input logic [45:0] d, input logic r);
    @(posedge clk);
    #1;
    v_i = v; w_i = w; addr_i = a; data_i = d; ready_i = r;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 10'd0, 46'd0, 1'b1);
  endtask

  task automatic rd_expect(input string nm, input logic [9:0] a, input logic [45:0] e);
    step(1'b1, 1'b0, a, 46'd0, 1'b1);
    idle();
    idle();
    @(negedge clk);
    chk({nm, "_v"}, v_o, 1);
    chk({nm, "_d"}, data_o, e);
  endtask

  task automatic wait_init();
    int k;
    k = 0;
    while (!init_done_o && k < 2000) begin
      idle();
      k++;
    end
    chk("init_wait", init_done_o, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = 46'({$urandom(), $urandom()});
      ref_mem[i]  = sram_mem[i];
    end
    reset_i = 1'b1; v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;

`ifdef SRAM_CTRL_INIT_ZERO_EN
    repeat (1023) @(posedge clk);
    @(negedge clk);
    chk("t6_init_busy_last", init_done_o, 0);
    @(negedge clk);
    chk("t6_init_done", init_done_o, 1);
    rd_expect("t6_rd0", 10'd0, 46'd0);
    rd_expect("t6_rd511", 10'd511, 46'd0);
    rd_expect("t6_rd1023", 10'd1023, 46'd0);
`else
    @(negedge clk);
    chk("init_done_after_reset", init_done_o, 1);
`endif

    // Write then read the same address back-to-back.
    step(1'b1, 1'b1, 10'd5, 46'h1234, 1'b1);
    step(1'b1, 1'b0, 10'd5, 46'd0, 1'b1);
    idle();
    @(negedge clk);
    chk("t1_v_early", v_o, 0);
    idle();
    @(negedge clk);
    chk("t1_v", v_o, 1);
    chk("t1_data", data_o, 46'h1234);

    // Streaming reads with no bubbles.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 10'(i), 46'h100 + 46'(i), 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) step(1'b1, 1'b0, 10'(i), 46'd0, 1'b1);
      else idle();
      @(negedge clk);
      if (i < 8) chk("t2_ready", ready_o, 1);
      if (i >= 2) begin
        chk("t2_v", v_o, 1);
        chk("t2_data", data_o, 46'h100 + 46'(i - 2));
      end
    end

    // Credit stall with consumer blocked.
    step(1'b1, 1'b1, 10'd4, 46'hA04, 1'b1);
    step(1'b1, 1'b0, 10'd1, 46'd0, 1'b0);
    step(1'b1, 1'b0, 10'd2, 46'd0, 1'b0);
    step(1'b1, 1'b0, 10'd3, 46'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 10'd4, 46'd0, 1'b0);
      @(negedge clk);
      chk("t3_stall_ready", ready_o, 0);
      chk("t3_stall_cen", sram_cen_o, 1);
    end
    step(1'b1, 1'b0, 10'd4, 46'd0, 1'b1);
    @(negedge clk);
    chk("t3_d1", data_o, 46'h101);
    chk("t3_still_full", ready_o, 0);
    step(1'b1, 1'b0, 10'd4, 46'd0, 1'b1);
    @(negedge clk);
    chk("t3_d2", data_o, 46'h102);
    chk("t3_ready_back", ready_o, 1);
    chk("t3_cen_4th", sram_cen_o, 0);
    idle();
    @(negedge clk);
    chk("t3_d3", data_o, 46'h103);
    idle();
    @(negedge clk);
    chk("t3_v4", v_o, 1);
    chk("t3_d4", data_o, 46'hA04);
    idle();
    @(negedge clk);
    chk("t3_drained", v_o, 0);

    // Reset with two reads in flight.
    step(1'b1, 1'b0, 10'd6, 46'd0, 1'b1);
    step(1'b1, 1'b0, 10'd7, 46'd0, 1'b1);
    @(posedge clk);
    #1 reset_i = 1'b1; v_i = 1'b0;
    @(negedge clk);
    chk("t4_rst_v", v_o, 0);
    @(posedge clk);
    #1 reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_no_stale", v_o, 0);
    end
    wait_init();
    step(1'b1, 1'b1, 10'd6, 46'h5A5A, 1'b1);
    rd_expect("t4_fresh", 10'd6, 46'h5A5A);

    // Top address.
    step(1'b1, 1'b1, 10'd0, 46'h0BAD, 1'b1);
    step(1'b1, 1'b1, 10'd1023, 46'h3FFF_FFFF_FFFF, 1'b1);
    rd_expect("t5_top", 10'd1023, 46'h3FFF_FFFF_FFFF);
    rd_expect("t5_zero", 10'd0, 46'h0BAD);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [9:0] a;
      a = ($urandom_range(0, 9) == 0) ? 10'(1023 - $urandom_range(0, 1)) : 10'($urandom_range(0, 15));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), a,
           46'({$urandom(), $urandom()}), 1'($urandom_range(0, 3) != 0));
    end
    repeat (10) idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
